lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_gen_pkg.sv | 28 ++
 rtl/lcd_timing_gen_if.sv | 11 +
 rtl/lcd_pattern_gen.sv | 36 +++
 rtl/lcd_timing_gen.sv | 153 +++++++++++++++
 tb/tb_lcd_timing_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_gen_pkg.sv
// rtl/lcd_timing_gen_pkg.sv - shared types and default 1600x900 timing for the LCD timing generator
package lcd_timing_pkg;

   typedef enum logic [1:0] {
      MODE_EXT     = 2'd0,
      MODE_BARS    = 2'd1,
      MODE_CHECKER = 2'd2,
      MODE_WHITE   = 2'd3
   } mode_e;

   typedef logic [11:0] coord_t;

   localparam int COORD_LIMIT  = 4096;

   localparam int DEF_H_ACTIVE = 1600;
   localparam int DEF_H_FP     = 48;
   localparam int DEF_H_SYNC   = 32;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 900;
   localparam int DEF_V_FP     = 3;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 18;

   function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// rtl/lcd_timing_gen_if.sv - external pixel stream between a pixel source and the timing generator
interface lcd_timing_gen_if #(
   parameter int CW = 6
);
   logic            pix_valid;
   logic [3*CW-1:0] pix_rgb;
   logic            pix_ready;

   modport master (output pix_valid, output pix_rgb, input pix_ready);
   modport slave  (input pix_valid, input pix_rgb, output pix_ready);
endinterface

// File: rtl/lcd_pattern_gen.sv
// rtl/lcd_pattern_gen.sv - combinational test patterns (bars, checkerboard, white) from pixel coordinates
module lcd_pattern_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int CW       = 6
) (
   input  mode_e           mode,
   input  coord_t          x,
   input  coord_t          y,
   output logic [3*CW-1:0] rgb
);
   localparam coord_t Q1 = coord_t'(H_ACTIVE / 4);
   localparam coord_t Q2 = coord_t'(H_ACTIVE / 2);
   localparam coord_t Q3 = coord_t'((3 * H_ACTIVE) / 4);
   localparam logic [CW-1:0] FULL = '1;
   localparam logic [CW-1:0] ZERO = '0;

   logic unused_y;
   assign unused_y = ^{y[11:4], y[2:0]};

   always_comb begin
      rgb = '0;
      case (mode)
         MODE_BARS: begin
            if (x < Q1)      rgb = {FULL, ZERO, ZERO};
            else if (x < Q2) rgb = {ZERO, FULL, ZERO};
            else if (x < Q3) rgb = {ZERO, ZERO, FULL};
            else             rgb = {FULL, FULL, FULL};
         end
         MODE_CHECKER: if (x[3] ^ y[3]) rgb = '1;
         MODE_WHITE:   rgb = '1;
         default:      rgb = '0;
      endcase
   end
endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - LCD panel timing generator; LCD_PATTERN_EN adds the internal pattern source
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter int   CW       = 6,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [1:0]      mode,
   lcd_timing_gen_if.slave pix,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic [3*CW-1:0] rgb_out,
   output coord_t          pos_x,
   output coord_t          pos_y,
   output logic            frame_start,
   output logic            underrun
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_size_check
         $error("lcd_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
      end
   endgenerate

   localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
   localparam coord_t H_SS_C   = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t H_SE_C   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t H_LAST_C = coord_t'(H_TOTAL - 1);
   localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
   localparam coord_t V_SS_C   = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t V_SE_C   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam coord_t V_LAST_C = coord_t'(V_TOTAL - 1);

   coord_t          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   coord_t          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic            hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic            frame_start_q, frame_start_d, underrun_q, underrun_d;
   logic [3*CW-1:0] rgb_q, rgb_d;

   logic            active, frame_origin;
   mode_e           mode_cur;
   logic [3*CW-1:0] pat_rgb;

   assign active       = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
   assign frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

`ifdef LCD_PATTERN_EN
   mode_e mode_eff_q, mode_eff_d;

   // The new mode already applies to pixel (0,0) of the frame in which it is latched.
   assign mode_cur   = frame_origin ? mode_e'(mode) : mode_eff_q;
   assign mode_eff_d = en ? mode_cur : mode_eff_q;

   always_ff @(posedge clk) begin
      if (!rst) mode_eff_q <= MODE_EXT;
      else      mode_eff_q <= mode_eff_d;
   end

   lcd_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .CW       (CW)
   ) u_pattern (
      .mode (mode_cur),
      .x    (h_cnt_q),
      .y    (v_cnt_q),
      .rgb  (pat_rgb)
   );
`else
   logic unused_mode;
   assign unused_mode = ^mode;
   assign mode_cur    = MODE_EXT;
   assign pat_rgb     = '0;
`endif

   assign pix.pix_ready = active && en && (mode_cur == MODE_EXT);

   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      pos_x_d       = pos_x_q;
      pos_y_d       = pos_y_q;
      de_d          = 1'b0;
      hsync_d       = ~SYNC_POL;
      vsync_d       = ~SYNC_POL;
      rgb_d         = '0;
      frame_start_d = 1'b0;
      underrun_d    = underrun_q;
      if (en) begin
         h_cnt_d = (h_cnt_q == H_LAST_C) ? '0 : h_cnt_q + 12'd1;
         if (h_cnt_q == H_LAST_C)
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 12'd1;
         pos_x_d       = h_cnt_q;
         pos_y_d       = v_cnt_q;
         de_d          = active;
         frame_start_d = frame_origin;
         if (in_window(h_cnt_q, H_SS_C, H_SE_C)) hsync_d = SYNC_POL;
         if (in_window(v_cnt_q, V_SS_C, V_SE_C)) vsync_d = SYNC_POL;
         if (active)
            rgb_d = (mode_cur != MODE_EXT) ? pat_rgb :
                    (pix.pix_valid ? pix.pix_rgb : '0);
         if (pix.pix_ready && !pix.pix_valid) underrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pos_x_q       <= '0;
         pos_y_q       <= '0;
         de_q          <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pos_x_q       <= pos_x_d;
         pos_y_q       <= pos_y_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb_out     = rgb_q;
   assign pos_x       = pos_x_q;
   assign pos_y       = pos_y_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - scoreboard bench for lcd_timing_gen with a frame-position reference model
module tb_lcd_timing_gen;
   import lcd_timing_pkg::*;

   localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
   localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FT = HT * VT;
`ifdef LCD_PATTERN_EN
   localparam bit PAT_EN = 1'b1;
`else
   localparam bit PAT_EN = 1'b0;
`endif

   typedef struct {
      int          due;
      logic        val;
   } rdy_t;

   typedef struct {
      int          due;
      logic        de, hs, vs, fs, ur;
      logic [17:0] rgb;
      logic [11:0] px, py;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [1:0]  mode;
   logic        hsync, vsync, de, frame_start, underrun;
   logic [17:0] rgb_out;
   coord_t      pos_x, pos_y;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   rdy_t rdy_q[$];
   exp_t out_q[$];

   int          m_p = 0, m_mode = 0;
   logic        m_ur = 1'b0, m_known = 1'b0;
   logic [11:0] m_px = '0, m_py = '0;

   lcd_timing_gen_if #(.CW(6)) pix_if ();

   lcd_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .CW(6), .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .pix(pix_if),
      .hsync(hsync), .vsync(vsync), .de(de), .rgb_out(rgb_out),
      .pos_x(pos_x), .pos_y(pos_y), .frame_start(frame_start), .underrun(underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp_v);
      end
   endtask

   function automatic logic [17:0] pattern(input int em, input int h, input int v);
      case (em)
         1: case ((h * 4) / HA)
               0: return 18'h3F000;
               1: return 18'h00FC0;
               2: return 18'h0003F;
               default: return 18'h3FFFF;
            endcase
         2: return (((h / 8) % 2) != ((v / 8) % 2)) ? 18'h3FFFF : 18'h0;
         3: return 18'h3FFFF;
         default: return 18'h0;
      endcase
   endfunction

   // Reference: one linear position in the frame, advanced once per enabled cycle.
   task automatic model_step();
      int h, v, em;
      logic act, rdy;
      exp_t x;
      h   = m_p % HT;
      v   = m_p / HT;
      act = (h < HA) && (v < VA);
      em  = PAT_EN ? ((m_p == 0) ? int'(mode) : m_mode) : 0;
      rdy = act && en && (em == 0);
      if (m_known) rdy_q.push_back('{due: cyc, val: rdy});
      x.due = cyc + 1;
      if (!rst) begin
         m_p = 0; m_mode = 0; m_ur = 1'b0; m_px = '0; m_py = '0; m_known = 1'b1;
         x.de = 0; x.hs = 1; x.vs = 1; x.fs = 0; x.rgb = '0;
      end else if (en) begin
         x.de  = act;
         x.hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
         x.vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
         x.fs  = (m_p == 0);
         x.rgb = !act ? 18'h0 : (em != 0) ? pattern(em, h, v) :
                 (pix_if.pix_valid ? pix_if.pix_rgb : 18'h0);
         if (rdy && !pix_if.pix_valid) m_ur = 1'b1;
         m_px = 12'(h); m_py = 12'(v);
         m_mode = em;
         m_p = (m_p + 1) % FT;
      end else begin
         x.de = 0; x.hs = 1; x.vs = 1; x.fs = 0; x.rgb = '0;
      end
      x.ur = m_ur; x.px = m_px; x.py = m_py;
      if (m_known) out_q.push_back(x);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic run_to(input int p);
      for (int g = 0; g < 2 * FT && m_p != p; g++) step();
      check("reach_position", 32'(m_p), 32'(p));
   endtask

   always @(negedge clk) begin
      rdy_t r;
      exp_t e;
      while (rdy_q.size() > 0 && rdy_q[0].due <= cyc) begin
         r = rdy_q.pop_front();
         if (r.due == cyc) check("pix_ready", 32'(pix_if.pix_ready), 32'(r.val));
      end
      while (out_q.size() > 0 && out_q[0].due <= cyc) begin
         e = out_q.pop_front();
         if (e.due == cyc) begin
            check("de", 32'(de), 32'(e.de));
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            check("underrun", 32'(underrun), 32'(e.ur));
            check("rgb_out", 32'(rgb_out), 32'(e.rgb));
            check("pos_x", 32'(pos_x), 32'(e.px));
            check("pos_y", 32'(pos_y), 32'(e.py));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] ramp;
      ramp = '0;
      rst = 1'b0; en = 1'b0; mode = 2'd0;
      pix_if.pix_valid = 1'b0; pix_if.pix_rgb = '0;
      @(posedge clk);
      #2;
      repeat (3) step();

      rst = 1'b1; en = 1'b1; pix_if.pix_valid = 1'b1;
      for (int i = 0; i < 2 * FT + 5; i++) begin
         pix_if.pix_rgb = ramp;
         ramp = ramp + 18'd1;
         step();
      end

      run_to(20);
      pix_if.pix_valid = 1'b0;
      step();
      pix_if.pix_valid = 1'b1;
      run_to(0);

      run_to(30);
      mode = 2'd1;
      run_to(0);
      repeat (FT) step();
      run_to(30);
      mode = 2'd3;
      run_to(0);
      repeat (FT) step();
      mode = 2'd2;
      run_to(0);
      repeat (FT) step();
      mode = 2'd0;
      run_to(0);

      run_to(HT + 3);
      en = 1'b0;
      repeat (5) step();
      en = 1'b1;
      repeat (30) step();

      for (int i = 0; i < 700; i++) begin
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
         pix_if.pix_valid = ($urandom_range(0, 9) != 0);
         pix_if.pix_rgb = 18'($urandom);
         rst = ($urandom_range(0, 199) != 0);
         step();
      end

      rst = 1'b1; en = 1'b1; pix_if.pix_valid = 1'b1;
      run_to(40);
      rst = 1'b0;
      step();
      rst = 1'b1;
      repeat (20) step();

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(rdy_q.size() + out_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
